// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the MIPS control-signal pipeline:
// forwarding select encoding, default bundle widths and control-bit positions.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    localparam int DEF_EX_W      = 4;
    localparam int DEF_MEM_W     = 2;
    localparam int DEF_WB_W      = 2;
    localparam int DEF_REG_AW    = 5;
    localparam int DEF_MEMRD_BIT = 0;
    localparam int DEF_REGWR_BIT = 1;

    // The younger producer (EX/MEM) holds the newer value, so it wins.
    function automatic logic [1:0] fwd_encode(input logic hit_exmem, input logic hit_memwb);
        if (hit_exmem) begin
            return FWD_EXMEM;
        end
        if (hit_memwb) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Forwarding comparator for one ALU operand: picks EX/MEM, MEM/WB or the
// register file for the source register of the instruction sitting in EX.
module pipe_fwd_select
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              i_src_valid,
    input  logic [REG_AW-1:0] i_src_reg,
    input  logic              i_exmem_valid,
    input  logic              i_exmem_regwr,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_memwb_valid,
    input  logic              i_memwb_regwr,
    input  logic [REG_AW-1:0] i_memwb_rd,
    output logic [1:0]        o_sel
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    // Register 0 is hard-wired, so a write to it never forwards.
    assign w_exmem_hit = i_src_valid & i_exmem_valid & i_exmem_regwr
                       & (i_exmem_rd != '0) & (i_exmem_rd == i_src_reg);
    assign w_memwb_hit = i_src_valid & i_memwb_valid & i_memwb_regwr
                       & (i_memwb_rd != '0) & (i_memwb_rd == i_src_reg);

    assign o_sel = fwd_encode(w_exmem_hit, w_memwb_hit);

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Control-bundle pipeline ID/EX -> EX/MEM -> MEM/WB with load-use / RAW
// hazard detection, bubble insertion, redirect flush, forwarding and a stall counter.
module pipe_ctrl_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int EX_W      = DEF_EX_W,
    parameter int MEM_W     = DEF_MEM_W,
    parameter int WB_W      = DEF_WB_W,
    parameter int REG_AW    = DEF_REG_AW,
    parameter int MEMRD_BIT = DEF_MEMRD_BIT,
    parameter int REGWR_BIT = DEF_REGWR_BIT,
    parameter int FWD_EN    = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [EX_W-1:0]   id_ex_i,
    input  logic [MEM_W-1:0]  id_mem_i,
    input  logic [WB_W-1:0]   id_wb_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              redirect_i,
    output logic [EX_W-1:0]   ex_ex_o,
    output logic [MEM_W-1:0]  mem_mem_o,
    output logic [WB_W-1:0]   wb_wb_o,
    output logic              ex_valid_o,
    output logic              mem_valid_o,
    output logic              wb_valid_o,
    output logic              stall_o,
    output logic              flush_ifid_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              r_idex_valid;
    logic [EX_W-1:0]   r_idex_ex;
    logic [MEM_W-1:0]  r_idex_mem;
    logic [WB_W-1:0]   r_idex_wb;
    logic [REG_AW-1:0] r_idex_rs;
    logic [REG_AW-1:0] r_idex_rt;
    logic [REG_AW-1:0] r_idex_rd;

    logic              r_exmem_valid;
    logic [MEM_W-1:0]  r_exmem_mem;
    logic [WB_W-1:0]   r_exmem_wb;
    logic [REG_AW-1:0] r_exmem_rd;

    logic              r_memwb_valid;
    logic [WB_W-1:0]   r_memwb_wb;
    logic [REG_AW-1:0] r_memwb_rd;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic       w_load_use;
    logic       w_raw_idex;
    logic       w_raw_exmem;
    logic       w_hazard;
    logic       w_stall;
    logic       w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_load_use = id_valid_i & r_idex_valid & r_idex_mem[MEMRD_BIT]
                      & (r_idex_rd != '0)
                      & ((r_idex_rd == id_rs_i) | (r_idex_rd == id_rt_i));

    // Without forwarding every in-flight writer ahead of MEM/WB must drain;
    // MEM/WB itself is safe because the register file writes first half-cycle.
    assign w_raw_idex  = r_idex_valid & r_idex_wb[REGWR_BIT] & (r_idex_rd != '0)
                       & ((r_idex_rd == id_rs_i) | (r_idex_rd == id_rt_i));
    assign w_raw_exmem = r_exmem_valid & r_exmem_wb[REGWR_BIT] & (r_exmem_rd != '0)
                       & ((r_exmem_rd == id_rs_i) | (r_exmem_rd == id_rt_i));

    assign w_hazard = (FWD_EN != 0) ? w_load_use
                                    : (w_load_use | w_raw_idex | w_raw_exmem);

    assign w_stall  = w_hazard & ~redirect_i;
    assign w_bubble = w_stall | redirect_i | ~id_valid_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idex_valid <= 1'b0;
            r_idex_ex    <= '0;
            r_idex_mem   <= '0;
            r_idex_wb    <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
        end else if (w_bubble) begin
            r_idex_valid <= 1'b0;
            r_idex_ex    <= '0;
            r_idex_mem   <= '0;
            r_idex_wb    <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
        end else begin
            r_idex_valid <= 1'b1;
            r_idex_ex    <= id_ex_i;
            r_idex_mem   <= id_mem_i;
            r_idex_wb    <= id_wb_i;
            r_idex_rs    <= id_rs_i;
            r_idex_rt    <= id_rt_i;
            r_idex_rd    <= id_rd_i;
        end
    end

    // Bubbles in ID/EX are already all-zero, so later stages just copy forward.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exmem_valid <= 1'b0;
            r_exmem_mem   <= '0;
            r_exmem_wb    <= '0;
            r_exmem_rd    <= '0;
            r_memwb_valid <= 1'b0;
            r_memwb_wb    <= '0;
            r_memwb_rd    <= '0;
        end else begin
            r_exmem_valid <= r_idex_valid;
            r_exmem_mem   <= r_idex_mem;
            r_exmem_wb    <= r_idex_wb;
            r_exmem_rd    <= r_idex_rd;
            r_memwb_valid <= r_exmem_valid;
            r_memwb_wb    <= r_exmem_wb;
            r_memwb_rd    <= r_exmem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            pipe_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
                .i_src_valid   (r_idex_valid),
                .i_src_reg     (r_idex_rs),
                .i_exmem_valid (r_exmem_valid),
                .i_exmem_regwr (r_exmem_wb[REGWR_BIT]),
                .i_exmem_rd    (r_exmem_rd),
                .i_memwb_valid (r_memwb_valid),
                .i_memwb_regwr (r_memwb_wb[REGWR_BIT]),
                .i_memwb_rd    (r_memwb_rd),
                .o_sel         (w_fwd_a)
            );
            pipe_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
                .i_src_valid   (r_idex_valid),
                .i_src_reg     (r_idex_rt),
                .i_exmem_valid (r_exmem_valid),
                .i_exmem_regwr (r_exmem_wb[REGWR_BIT]),
                .i_exmem_rd    (r_exmem_rd),
                .i_memwb_valid (r_memwb_valid),
                .i_memwb_regwr (r_memwb_wb[REGWR_BIT]),
                .i_memwb_rd    (r_memwb_rd),
                .o_sel         (w_fwd_b)
            );
        end else begin : g_no_fwd
            assign w_fwd_a = FWD_RF;
            assign w_fwd_b = FWD_RF;
        end
    endgenerate

    assign ex_ex_o      = r_idex_ex;
    assign mem_mem_o    = r_exmem_mem;
    assign wb_wb_o      = r_memwb_wb;
    assign ex_valid_o   = r_idex_valid;
    assign mem_valid_o  = r_exmem_valid;
    assign wb_valid_o   = r_memwb_valid;
    assign stall_o      = w_stall;
    assign flush_ifid_o = redirect_i;
    assign fwd_a_o      = w_fwd_a;
    assign fwd_b_o      = w_fwd_b;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl_hazard_unit.md
Name: pipe_ctrl_hazard_unit

Overview:
Parametrised control-signal pipeline for the 5-stage MIPS core, the successor to the fixed 8-bit EX/MEM/WB control bundle wiring. It takes decoded EX, MEM and WB control bundles plus register numbers from ID and carries them through the ID/EX, EX/MEM and MEM/WB registers. It also adds load-use hazard detection, stall and bubble insertion, branch/jump flush, forwarding selects, and a saturating stall counter. It sits between Controller and DataPath, replacing the raw control-bundle concatenation.

Parameters:
EX_W, 4, width of EX control bundle
MEM_W, 2, width of MEM control bundle
WB_W, 2, width of WB control bundle
REG_AW, 5, register number width
MEMRD_BIT, 0, index of MemRead inside the MEM bundle
REGWR_BIT, 1, index of RegWrite inside the WB bundle
FWD_EN, 1, 1 = forwarding mode; 0 = stall on every RAW hazard
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
id_valid_i  in  1  ID holds a real instruction
id_ex_i  in  EX_W  EX bundle from Controller
id_mem_i  in  MEM_W  MEM bundle
id_wb_i  in  WB_W  WB bundle
id_rs_i  in  REG_AW  source register rs
id_rt_i  in  REG_AW  source register rt
id_rd_i  in  REG_AW  destination register, already selected
redirect_i  in  1  taken branch/jump resolved in EX
ex_ex_o  out  EX_W  EX bundle of the EX-stage instruction
mem_mem_o  out  MEM_W  MEM bundle of the MEM-stage instruction
wb_wb_o  out  WB_W  WB bundle of the WB-stage instruction
ex_valid_o, mem_valid_o, wb_valid_o  out  1 each  stage holds a real instruction
stall_o  out  1  hold PC and IF/ID
flush_ifid_o  out  1  squash IF/ID
fwd_a_o  out  2  ALU A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b_o  out  2  same, for ALU B
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset==0 at a clock edge) clears every stage register (valid, bundles, register numbers) and stall_cnt_o. All outputs then read 0. Reset has priority over all other activity, including in-flight instructions.
- Stage state:
  - IDEX holds {valid, ex, mem, wb, rs, rt, rd}.
  - EXMEM holds {valid, mem, wb, rd}.
  - MEMWB holds {valid, wb, rd}.
- Latency: bundles presented at ID appear on ex_ex_o after 1 cycle, mem_mem_o after 2, wb_wb_o after 3. EXMEM and MEMWB advance every cycle unconditionally.
- Bubble: valid=0 and all bundles zeroed. Invalid stages always drive zero bundles.
- Load-use hazard (lu): id_valid_i & IDEX.valid & IDEX.mem[MEMRD_BIT] & IDEX.rd!=0 & (IDEX.rd==id_rs_i | IDEX.rd==id_rt_i).
- RAW hazard (FWD_EN=0 only): lu, or a valid IDEX/EXMEM entry with wb[REGWR_BIT] and rd!=0 matching id_rs_i or id_rt_i. MEMWB is excluded because the register file writes in the first half-cycle.
- stall_o = hazard & ~redirect_i, combinational. When stall_o is high, IDEX loads a bubble.
- flush_ifid_o = redirect_i. When redirect_i is high, IDEX loads a bubble. Redirect beats stall when both occur in the same cycle.
- Otherwise IDEX loads the ID inputs, with valid = id_valid_i. An ID entry with id_valid_i=0 enters as a bubble.
- Forwarding (FWD_EN=1), combinational from registered state; fwd_a_o shown, fwd_b_o uses IDEX.rt:
  - 10 if EXMEM.valid & EXMEM.wb[REGWR_BIT] & EXMEM.rd!=0 & EXMEM.rd==IDEX.rs;
  - else 01 under the same test on MEMWB;
  - else 00.
  - EX/MEM takes priority over MEM/WB.
  - Invalid IDEX gives 00.
- With FWD_EN=0, fwd_a_o and fwd_b_o are constant 00.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at 2^CNT_W-1; it never wraps.

Decomposition:
- Package mips_pipe_pkg holds:
  - forwarding select constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - default bundle widths;
  - default MEMRD_BIT and REGWR_BIT.
- One sub-module, pipe_fwd_select: combinational forwarding comparator, instantiated twice (A and B).
- Stage registers and hazard logic stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with id_valid_i=1 and nonzero bundles -> all outputs 0, stall_cnt_o=0.
- Flow: id_ex_i=4'b1010, id_wb_i=2'b10, rd=3, single cycle -> ex_ex_o=1010 at +1, mem_valid_o=1 at +2, wb_wb_o=10 at +3, stall_o never set.
- Load-use: lw (mem=2'b01, rd=8), then an instruction with rs=8 -> stall_o=1 for exactly 1 cycle, ex_valid_o=0 the next cycle. When the dependent instruction reaches EX, fwd_a_o=01. stall_cnt_o=1.
- Forward priority: add rd=5, add rd=5, sub rs=5 rt=5 -> fwd_a_o=fwd_b_o=10. With one gap between producer and consumer -> 01. With rd=0 -> 00.
- Redirect vs stall: redirect_i=1 during a load-use hazard -> stall_o=0, flush_ifid_o=1, IDEX bubble, stall_cnt_o unchanged.
- FWD_EN=0, CNT_W=2: add rd=5 then rs=5 -> stall_o high for 2 cycles, fwd selects stay 00. Repeat the pair twice -> stall_cnt_o reaches 3 and holds at 3.
